instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage of the RISC-V core: owns the program counter, issues one request at a time to instruction memory, and holds the returned word until the decode stage accepts it. It sits directly upstream of the main decoder, which receives the opcode field of `instr`. Branch and jump redirects come back from execute as `redirect_valid`/`redirect_target`. The PCSrc-equivalent next-PC choice is made here.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `imem_req`  out  1  request valid toward instruction memory
- `imem_addr`  out  32  word-aligned fetch address
- `imem_ready`  in  1  memory accepts request this cycle
- `imem_rvalid`  in  1  read data valid
- `imem_rdata`  in  32  instruction word
- `instr_valid`  out  1  `instr`/`pc` hold a fetched instruction
- `instr`  out  32  instruction to decoder (opcode = [6:0])
- `pc`  out  32  address of `instr`
- `pc_plus4`  out  32  `pc + 4`, for jump link write-back
- `instr_ready`  in  1  decode/execute consumes `instr` this cycle
- `redirect_valid`  in  1  taken branch or jump
- `redirect_target`  in  32  new PC; bits [1:0] forced to 0 internally

## Operation
- State register: IDLE, FETCH, WAIT, DROP, VALID. Reset value: IDLE.
- Internal `fetch_pc` register, reset to RESET_PC.
- IDLE: move to FETCH unconditionally.
- FETCH: `imem_req`=1, `imem_addr`=`fetch_pc`. On `imem_ready`, move to WAIT.
- WAIT: on `imem_rvalid`, capture `instr`←`imem_rdata` and `pc`←`fetch_pc`, then move to VALID.
- VALID: `instr_valid`=1. On `instr_ready`, set `fetch_pc`←`fetch_pc`+4 and move to FETCH.
- DROP: waits for the stale response. On `imem_rvalid`, discard the data and move to FETCH.
- Redirect (`redirect_valid`=1) overrides all other transitions and sets `fetch_pc`←{`redirect_target`[31:2],2'b00}. Next state by current state:
  - IDLE: FETCH.
  - FETCH with `imem_ready`=1: DROP (old address was accepted).
  - FETCH with `imem_ready`=0: FETCH (new address presented next cycle).
  - WAIT with `imem_rvalid`=1: FETCH, data discarded.
  - WAIT with `imem_rvalid`=0: DROP.
  - DROP: DROP.
  - VALID: FETCH. The held instruction counts as consumed whether or not `instr_ready` is high.
- `imem_rvalid` is ignored in IDLE, FETCH and VALID.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- Reset outputs:
  - `imem_req`=0
  - `imem_addr`=RESET_PC
  - `instr_valid`=0
  - `instr`=32'h0000_0013 (NOP)
  - `pc`=RESET_PC
  - `pc_plus4`=RESET_PC+4
- Reset mid-operation returns to IDLE. Any outstanding memory response is dropped, because `imem_rvalid` is ignored in IDLE and FETCH.

## Timing
- At most one outstanding memory request.
- `imem_req` and `instr_valid` are registered-state decodes with no combinational path from inputs.
- Best case with zero-latency memory: request in cycle N, `imem_rvalid` in N+1, `instr_valid` in N+2. Three cycles per instruction when `instr_ready` is held high.
- `instr`, `pc` and `pc_plus4` are stable for the whole time `instr_valid`=1.
- A redirect in cycle N gives `imem_addr`=target in cycle N+1, unless the state passes through DROP first.

## Structure
- Shared package `fetch_pkg` holds:
  - state enum `fetch_state_t`
  - `NOP_INSTR` = 32'h0000_0013
  - `XLEN` = 32
- No sub-module. Next-PC mux and FSM fit in one module (~150 lines).

## Test plan
- **Reset release:** `imem_ready`=1, rvalid one cycle later, rdata=32'h0000_0003, `instr_ready`=1 → `imem_addr`=0, then 4, then 8. The first `instr` has `pc`=0 and `pc_plus4`=4.
- **Decode stall:** hold `instr_ready`=0 for 5 cycles → `instr_valid` stays 1, `instr`/`pc` unchanged, `imem_req`=0.
- **Redirect in VALID:** `redirect_target`=32'h0000_0102 → next `imem_addr`=32'h0000_0100 and `instr_valid`=0.
- **Redirect in WAIT before data:** data 32'hDEAD_BEEF arrives 3 cycles later → it is never presented on `instr`; the next fetch is at the target.
- **Simultaneous `imem_ready` and redirect in FETCH:** state goes to DROP, the stale response is discarded, then the target is fetched.
- **PC wrap and mid-flight reset:** `fetch_pc`=32'hFFFF_FFFC, consume → next `imem_addr`=0. Assert `reset` while in WAIT → stale rvalid is ignored and the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_DROP  = 3'd3,
        S_VALID = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, keeps one request in flight toward
// instruction memory and holds the returned word until decode takes it.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | leaving reset, nothing in flight
//   FETCH   | imem_req high, presenting fetch_pc
//   WAIT    | request accepted, waiting for its data
//   DROP    | request accepted but made stale by a redirect; discard data
//   VALID   | instr/pc hold a fetched word for decode
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target
);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_nxt;
    logic            capture;

    // Next state and next fetch PC; a redirect takes priority over everything.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        capture      = 1'b0;
        if (redirect_valid) begin
            fetch_pc_nxt = redirect_target & ~32'h0000_0003;
            case (state)
                S_IDLE:  state_nxt = S_FETCH;
                S_FETCH: state_nxt = imem_ready ? S_DROP : S_FETCH;
                S_WAIT:  state_nxt = imem_rvalid ? S_FETCH : S_DROP;
                S_DROP:  state_nxt = S_DROP;
                S_VALID: state_nxt = S_FETCH;
                default: state_nxt = S_IDLE;
            endcase
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_FETCH;
                S_FETCH: begin
                    if (imem_ready) state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        capture   = 1'b1;
                        state_nxt = S_VALID;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) state_nxt = S_FETCH;
                end
                S_VALID: begin
                    if (instr_ready) begin
                        fetch_pc_nxt = fetch_pc + 32'd4;
                        state_nxt    = S_FETCH;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State, fetch PC and the held instruction/PC pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            instr    <= NOP_INSTR;
            pc       <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            if (capture) begin
                instr <= imem_rdata;
                pc    <= fetch_pc;
            end
        end
    end

    // Outputs decode registered state only, so no input reaches them combinationally.
    always_comb begin
        imem_req    = (state == S_FETCH);
        instr_valid = (state == S_VALID);
        imem_addr   = fetch_pc;
        pc_plus4    = pc + 32'd4;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a transaction-level model checked every
// cycle plus directed scenarios with hand-computed values.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;

    int n_tests = 0;
    int n_fail  = 0;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0000_0003 : (a ^ 32'h1357_0000);
    endfunction

    // ---------------- memory responder state (driven from tick) ----------
    int          lat = 0;
    bit          pend = 0;
    int          cnt = 0;
    logic [31:0] pend_addr = 0;
    bit          ovr_en = 0;
    logic [31:0] ovr_data = 0;
    logic [31:0] acc_q[$];
    bit          seen_first = 0;
    logic [31:0] fv_pc, fv_pc4, fv_instr;

    task automatic tick();
        bit          acc;
        bit          rv;
        logic [31:0] a;
        acc = imem_req && imem_ready && !reset;
        rv  = imem_rvalid;
        a   = imem_addr;
        @(posedge clk);
        #1;
        if (rv) imem_rvalid = 1'b0;
        if (acc) begin
            pend = 1; pend_addr = a; cnt = lat;
            acc_q.push_back(a);
        end
        if (pend) begin
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = ovr_en ? ovr_data : mem_word(pend_addr);
                ovr_en = 0;
                pend   = 0;
            end else begin
                cnt--;
            end
        end
        if (instr_valid && !seen_first) begin
            seen_first = 1;
            fv_pc = pc; fv_pc4 = pc_plus4; fv_instr = instr;
        end
    endtask

    task automatic wait_valid(input string name, input int max);
        for (int i = 0; i < max; i++) begin
            if (instr_valid) return;
            tick();
        end
        chk({name, "_timeout"}, {31'b0, instr_valid}, 32'd1);
    endtask

    task automatic wait_accept(input string name, input int max);
        for (int i = 0; i < max; i++) begin
            if (imem_req && imem_ready) begin
                tick();
                return;
            end
            tick();
        end
        chk({name, "_timeout"}, {31'b0, imem_req}, 32'd1);
    endtask

    // ---------------- transaction-level model, checked every cycle -------
    bit          armed = 0;
    logic [31:0] m_addr = 32'h0;
    bit          m_have = 0;
    logic [31:0] m_instr = 32'h13;
    logic [31:0] m_pc = 32'h0;
    bit          m_out = 0;
    bit          m_stale = 0;
    logic [31:0] m_out_addr = 0;

    // Compare DUT against the model, then advance the model with the inputs
    // the DUT will sample at the coming rising edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("m_instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
            if (m_have) begin
                chk("m_instr", instr, m_instr);
                chk("m_pc", pc, m_pc);
                chk("m_pc_plus4", pc_plus4, m_pc + 32'd4);
                chk("m_no_req_while_held", {31'b0, imem_req}, 32'd0);
            end
            if (imem_req) begin
                chk("m_imem_addr", imem_addr, m_addr);
                chk("m_one_outstanding", {31'b0, m_out}, 32'd0);
            end
            if (reset) begin
                m_addr = 32'h0; m_have = 0; m_out = 0; m_stale = 0;
            end else begin
                if (redirect_valid) begin
                    m_have = 0;
                end else if (m_have && instr_ready) begin
                    m_have = 0;
                    m_addr = m_pc + 32'd4;
                end
                if (imem_rvalid && m_out) begin
                    if (!m_stale && !redirect_valid) begin
                        m_have = 1; m_instr = imem_rdata; m_pc = m_out_addr;
                    end
                    m_out = 0;
                end
                if (imem_req && imem_ready) begin
                    m_out = 1; m_out_addr = imem_addr; m_stale = redirect_valid;
                end
                if (redirect_valid) begin
                    m_addr = redirect_target & ~32'h3;
                    if (m_out) m_stale = 1;
                end
            end
        end
    end

    initial begin
        reset = 1; imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
        instr_ready = 0; redirect_valid = 0; redirect_target = 0;
        tick();
        armed = 1;
        tick(); tick();
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);

        // Reset release, streaming with zero-latency memory.
        reset = 0; imem_ready = 1; instr_ready = 1; lat = 0;
        for (int i = 0; i < 10; i++) tick();
        chk("stream_nacc_ge3", {31'b0, acc_q.size() >= 3}, 32'd1);
        if (acc_q.size() >= 3) begin
            chk("stream_addr0", acc_q[0], 32'h0);
            chk("stream_addr1", acc_q[1], 32'h4);
            chk("stream_addr2", acc_q[2], 32'h8);
        end
        chk("first_seen", {31'b0, seen_first}, 32'd1);
        chk("first_pc", fv_pc, 32'h0);
        chk("first_pc_plus4", fv_pc4, 32'h4);
        chk("first_instr", fv_instr, 32'h0000_0003);

        // Decode stall.
        instr_ready = 0;
        wait_valid("stall", 20);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
        end

        // Redirect while VALID, decode not ready.
        redirect_valid = 1; redirect_target = 32'h0000_0102;
        tick();
        redirect_valid = 0;
        chk("rdv_valid", {31'b0, instr_valid}, 32'd0);
        chk("rdv_req", {31'b0, imem_req}, 32'd1);
        chk("rdv_addr", imem_addr, 32'h0000_0100);
        wait_valid("rdv", 20);
        chk("rdv_pc", pc, 32'h0000_0100);
        chk("rdv_instr", instr, 32'h1357_0100);

        // Redirect in WAIT before slow data arrives.
        lat = 3; ovr_en = 1; ovr_data = 32'hDEAD_BEEF;
        instr_ready = 1;
        tick();
        instr_ready = 0;
        wait_accept("rdw", 20);
        lat = 0;
        redirect_valid = 1; redirect_target = 32'h0000_0200;
        tick();
        redirect_valid = 0;
        wait_valid("rdw", 30);
        chk("rdw_pc", pc, 32'h0000_0200);
        chk("rdw_instr", instr, 32'h1357_0200);

        // imem_ready and redirect together in FETCH.
        imem_ready = 0; instr_ready = 1;
        tick();
        instr_ready = 0;
        tick();
        chk("rdf_req", {31'b0, imem_req}, 32'd1);
        chk("rdf_addr_old", imem_addr, 32'h0000_0204);
        imem_ready = 1; lat = 1;
        redirect_valid = 1; redirect_target = 32'h0000_0300;
        tick();
        redirect_valid = 0; lat = 0;
        chk("rdf_drop_req", {31'b0, imem_req}, 32'd0);
        wait_valid("rdf", 30);
        chk("rdf_pc", pc, 32'h0000_0300);
        chk("rdf_instr", instr, 32'h1357_0300);

        // PC wrap.
        redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 0;
        wait_valid("wrap", 20);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'h0);
        chk("wrap_instr", instr, 32'hECA8_FFFC);
        instr_ready = 1;
        tick();
        instr_ready = 0;
        chk("wrap_req", {31'b0, imem_req}, 32'd1);
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset while WAIT; the stale response lands in FETCH and is ignored.
        lat = 2;
        wait_accept("mrst", 10);
        reset = 1; imem_ready = 0;
        tick();
        reset = 0; lat = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("mrst_valid", {31'b0, instr_valid}, 32'd0);
        chk("mrst_req", {31'b0, imem_req}, 32'd1);
        chk("mrst_addr", imem_addr, 32'h0);
        imem_ready = 1;
        wait_valid("mrst", 20);
        chk("mrst_pc", pc, 32'h0);
        chk("mrst_instr", instr, 32'h0000_0003);

        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
